// File: rtl/vga_text_engine.sv
// vga_text_engine: VGA text-mode engine (timing, cell fetch, CGA colouring, scroll, optional VGA_CURSOR_EN blink cursor)
module vga_text_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int COLS = 70,
  parameter int ROWS = 30,
  parameter int GLYPH_W = 9,
  parameter int GLYPH_H = 16,
  parameter int FONT_W = 12,
  parameter int ADDR_W = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic pclk,
  input  logic reset,
  input  logic [7:0] scroll_row,
  input  logic [7:0] cursor_col,
  input  logic [7:0] cursor_row,
  output logic [ADDR_W-1:0] txt_addr,
  input  logic [15:0] txt_data,
  output logic [8+$clog2(GLYPH_H)-1:0] font_addr,
  input  logic [FONT_W-1:0] font_data,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic VGA_HS,
  output logic VGA_VS,
  output logic VGA_BLANK_N,
  output logic VGA_SYNC_N,
  output logic frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int GXW = $clog2(GLYPH_W);
  localparam int GYW = $clog2(GLYPH_H);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [23:0] PAL [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [GXW-1:0] gx;
  logic [GYW-1:0] gy;
  logic [7:0] col, row, scroll_l;
  logic [8:0] psum, phys;
  logic h_end, v_end, f_end, gx_end, in_txt, act, hs, vs, cur;
  logic s1_v, s1_in, s1_act, s1_hs, s1_vs, s1_cur;
  logic [GXW-1:0] s1_gx;
  logic [GYW-1:0] s1_gy;
  logic s2_v, s2_in, s2_act, s2_hs, s2_vs, s2_cur, s2_nz;
  logic [GXW-1:0] s2_gx;
  logic [7:0] s2_attr;
  logic [23:0] rgb;
  assign h_end = h == HW'(H_TOTAL - 1);
  assign v_end = v == VW'(V_TOTAL - 1);
  assign f_end = h_end && v_end;
  assign gx_end = gx == GXW'(GLYPH_W - 1);
  // stage 0: pixel/line counters, cell sub-counters, scroll latched only at the frame boundary
  always_ff @(posedge pclk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
      gx <= '0;
      gy <= '0;
      col <= '0;
      row <= '0;
      scroll_l <= '0;
      frame_start <= 1'b0;
    end else begin
      h <= h_end ? '0 : h + 1'b1;
      gx <= (h_end || gx_end) ? '0 : gx + 1'b1;
      col <= h_end ? '0 : gx_end ? col + 8'd1 : col;
      if (h_end) begin
        v <= v_end ? '0 : v + 1'b1;
        gy <= v_end ? '0 : gy + 1'b1;
        row <= v_end ? '0 : (gy == '1) ? row + 8'd1 : row;
      end
      frame_start <= f_end;
      if (f_end) scroll_l <= (scroll_row >= 8'(ROWS)) ? scroll_row - 8'(ROWS) : scroll_row;
    end
  end
  assign psum = {1'b0, row} + {1'b0, scroll_l};
  assign phys = (psum >= 9'(ROWS)) ? psum - 9'(ROWS) : psum;
  assign in_txt = col < 8'(COLS) && row < 8'(ROWS);
  assign txt_addr = in_txt ? ADDR_W'(phys) * ADDR_W'(COLS) + ADDR_W'(col) : '0;
  assign act = h < HW'(H_ACTIVE) && v < VW'(V_ACTIVE);
  assign hs = !(h >= HW'(H_ACTIVE + H_FP) && h < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs = !(v >= VW'(V_ACTIVE + V_FP) && v < VW'(V_ACTIVE + V_FP + V_SYNC));
`ifdef VGA_CURSOR_EN
  logic [BW-1:0] bcnt;
  logic phase;
  // blink phase flips after every BLINK_FRAMES frame starts
  always_ff @(posedge pclk) begin
    if (reset) begin
      bcnt <= '0;
      phase <= 1'b0;
    end else if (f_end) begin
      bcnt <= (bcnt == BW'(BLINK_FRAMES - 1)) ? '0 : bcnt + 1'b1;
      phase <= phase ^ (bcnt == BW'(BLINK_FRAMES - 1));
    end
  end
  assign cur = phase && col == cursor_col && row == cursor_row && gy >= GYW'(GLYPH_H - 2);
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_col, cursor_row, 1'(BLINK_FRAMES)};
  assign cur = 1'b0;
`endif
  assign font_addr = s1_v ? {txt_data[7:0], s1_gy} : '0;
  // stages 1 and 2: carry cell position, flags and syncs alongside the two memory reads
  always_ff @(posedge pclk) begin
    if (reset) begin
      {s1_v, s1_in, s1_act, s1_cur} <= '0;
      {s1_hs, s1_vs} <= 2'b11;
      s1_gx <= '0;
      s1_gy <= '0;
      {s2_v, s2_in, s2_act, s2_cur, s2_nz} <= '0;
      {s2_hs, s2_vs} <= 2'b11;
      s2_gx <= '0;
      s2_attr <= '0;
    end else begin
      {s1_v, s1_in, s1_act, s1_cur, s1_hs, s1_vs} <= {1'b1, in_txt, act, cur, hs, vs};
      s1_gx <= gx;
      s1_gy <= gy;
      {s2_v, s2_in, s2_act, s2_cur, s2_hs, s2_vs} <= {s1_v, s1_in, s1_act, s1_cur, s1_hs, s1_vs};
      s2_nz <= txt_data[7:0] != 8'h00;
      s2_gx <= s1_gx;
      s2_attr <= txt_data[15:8];
    end
  end
  assign rgb = (!s2_v || !s2_act || !s2_in) ? 24'h000000 :
               (s2_cur || (s2_nz && font_data[s2_gx])) ? PAL[s2_attr[3:0]] : PAL[s2_attr[7:4]];
  // stage 3: output registers
  always_ff @(posedge pclk) begin
    if (reset) begin
      {VGA_R, VGA_G, VGA_B} <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= rgb;
      VGA_HS <= s2_hs;
      VGA_VS <= s2_vs;
      VGA_BLANK_N <= s2_act;
    end
  end
  assign VGA_SYNC_N = 1'b0;
endmodule
